// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_axi_bridge                                                |
// | Purpose  : Merges the core's instruction and data SRAM-like ports onto a |
// |            single AXI3 master, one transaction in flight, data first.    |
// | Option   : AXI_BRIDGE_RESP_CHECK_EN adds a sticky bus_err output.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cpu_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
`ifdef AXI_BRIDGE_RESP_CHECK_EN
  ,
  output logic        bus_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_RD_ADDR      = 3'd1,
    S_RD_DATA      = 3'd2,
    S_WR_ADDR_DATA = 3'd3,
    S_WR_RESP      = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner_data;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_aw_done;
  logic        r_w_done;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_r_hs;
  logic        w_b_hs;
  logic [3:0]  w_strb;

  // Routing is tracked internally, so the returned ids and rlast carry no information here.
`ifdef AXI_BRIDGE_RESP_CHECK_EN
  logic w_unused;
  assign w_unused = ^{rid, bid, rlast};
`else
  logic w_unused;
  assign w_unused = ^{rid, bid, rlast, rresp, bresp};
`endif

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_r_hs  = (r_state == S_RD_DATA) && rvalid;
  assign w_b_hs  = (r_state == S_WR_RESP) && bvalid;

  always_comb begin
    w_state_nxt  = r_state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_req) begin
          data_addr_ok = 1'b1;
          w_state_nxt  = data_wr ? S_WR_ADDR_DATA : S_RD_ADDR;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          w_state_nxt  = S_RD_ADDR;
        end
      end
      S_RD_ADDR: if (arready) w_state_nxt = S_RD_DATA;
      S_RD_DATA: begin
        if (rvalid) begin
          inst_data_ok = !r_owner_data;
          data_data_ok = r_owner_data;
          w_state_nxt  = S_IDLE;
        end
      end
      S_WR_ADDR_DATA: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bvalid) begin
          data_data_ok = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_owner_data <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (data_addr_ok) begin
        r_owner_data <= 1'b1;
        r_wr         <= data_wr;
        r_size       <= data_size;
        r_addr       <= data_addr;
        r_wdata      <= data_wdata;
        r_aw_done    <= 1'b0;
        r_w_done     <= 1'b0;
      end else if (inst_addr_ok) begin
        r_owner_data <= 1'b0;
        r_wr         <= 1'b0;
        r_size       <= 2'd2;
        r_addr       <= inst_addr;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

`ifdef AXI_BRIDGE_RESP_CHECK_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bus_err <= 1'b0;
    end else if ((w_r_hs && (rresp != 2'b00)) || (w_b_hs && (bresp != 2'b00))) begin
      bus_err <= 1'b1;
    end
  end
`endif

  // Strobe is gated by the latched store flag so it reads zero out of reset and on loads.
  always_comb begin
    w_strb = 4'b0000;
    case (r_size)
      2'd0:    w_strb = 4'b0001 << r_addr[1:0];
      2'd1:    w_strb = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

  assign inst_rdata = rdata;
  assign data_rdata = rdata;

  assign arid    = r_owner_data ? DATA_ID : INST_ID;
  assign araddr  = r_addr;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, r_size};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (r_state == S_RD_ADDR);
  assign rready  = (r_state == S_RD_DATA);

  assign awid    = r_owner_data ? DATA_ID : 4'd0;
  assign awaddr  = r_addr;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, r_size};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (r_state == S_WR_ADDR_DATA) && !r_aw_done;

  assign wid    = r_owner_data ? DATA_ID : 4'd0;
  assign wdata  = r_wdata;
  assign wstrb  = r_wr ? w_strb : 4'b0000;
  assign wlast  = 1'b1;
  assign wvalid = (r_state == S_WR_ADDR_DATA) && !r_w_done;
  assign bready = (r_state == S_WR_RESP);

endmodule
`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cpu_axi_bridge                                             |
// | Purpose  : Directed vector table plus hand sequences for cpu_axi_bridge. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cpu_axi_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, arlen, arcache, rid;
  logic [31:0] araddr, rdata;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock, rresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache, wid, wstrb, bid;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef AXI_BRIDGE_RESP_CHECK_EN
  logic        bus_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cpu_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef AXI_BRIDGE_RESP_CHECK_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  exp_id;
    logic [2:0]  exp_size;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic smp();
    @(negedge aclk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0,        32'h3C010001, 4'd0, 3'd2, 4'b0000};
    vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h80000003, 32'hAB000000, 32'h0,        4'd1, 3'd0, 4'b1000};
    vecs[2] = '{1'b1, 1'b1, 2'd1, 32'h80000002, 32'h12340000, 32'h0,        4'd1, 3'd1, 4'b1100};
    vecs[3] = '{1'b1, 1'b1, 2'd1, 32'h80000000, 32'h00005678, 32'h0,        4'd1, 3'd1, 4'b0011};
    vecs[4] = '{1'b1, 1'b1, 2'd2, 32'h80000010, 32'hCAFEF00D, 32'h0,        4'd1, 3'd2, 4'b1111};
    vecs[5] = '{1'b1, 1'b1, 2'd0, 32'h80000001, 32'h0000CD00, 32'h0,        4'd1, 3'd0, 4'b0010};
    vecs[6] = '{1'b1, 1'b0, 2'd2, 32'h80001000, 32'h0,        32'hDEADBEEF, 4'd1, 3'd2, 4'b0000};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 32'h80001002, 32'h0,        32'h000000A5, 4'd1, 3'd0, 4'b0000};

    areset = 1'b1;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
    data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    tick(); tick();
    smp();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_bready", {31'd0, bready}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
    chk("rst_ids", {20'd0, arid, awid, wid}, 32'd0);
`ifdef AXI_BRIDGE_RESP_CHECK_EN
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
`endif
    tick();
    areset = 1'b0;
    tick();

    // Vector table: each record is one complete transaction at zero-wait slave timing.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_data) begin
        data_req = 1; data_wr = vecs[i].wr; data_size = vecs[i].size;
        data_addr = vecs[i].addr; data_wdata = vecs[i].wdata;
      end else begin
        inst_req = 1; inst_addr = vecs[i].addr;
      end
      smp();
      chk($sformatf("v%0d_addr_ok", i), {30'd0, inst_addr_ok, data_addr_ok},
          vecs[i].is_data ? 32'd1 : 32'd2);
      tick();
      inst_req = 0; data_req = 0;
      if (vecs[i].wr) begin
        awready = 1; wready = 1;
        smp();
        chk($sformatf("v%0d_awvalid_wvalid", i), {30'd0, awvalid, wvalid}, 32'd3);
        chk($sformatf("v%0d_awaddr", i), awaddr, vecs[i].addr);
        chk($sformatf("v%0d_awsize", i), {29'd0, awsize}, {29'd0, vecs[i].exp_size});
        chk($sformatf("v%0d_wstrb", i), {28'd0, wstrb}, {28'd0, vecs[i].exp_strb});
        chk($sformatf("v%0d_wdata", i), wdata, vecs[i].wdata);
        chk($sformatf("v%0d_awid_wid_wlast_awlen", i), {19'd0, awid, wid, wlast, awlen},
            {19'd0, vecs[i].exp_id, vecs[i].exp_id, 1'b1, 4'd0});
        tick();
        awready = 0; wready = 0; bvalid = 1;
        smp();
        chk($sformatf("v%0d_bready", i), {31'd0, bready}, 32'd1);
        chk($sformatf("v%0d_data_ok", i), {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        tick();
        bvalid = 0;
      end else begin
        arready = 1;
        smp();
        chk($sformatf("v%0d_arvalid", i), {31'd0, arvalid}, 32'd1);
        chk($sformatf("v%0d_araddr", i), araddr, vecs[i].addr);
        chk($sformatf("v%0d_arid_arsize_arlen", i), {21'd0, arid, arsize, arlen},
            {21'd0, vecs[i].exp_id, vecs[i].exp_size, 4'd0});
        tick();
        arready = 0; rvalid = 1; rdata = vecs[i].rdata;
        smp();
        chk($sformatf("v%0d_rready", i), {31'd0, rready}, 32'd1);
        chk($sformatf("v%0d_data_ok", i), {30'd0, inst_data_ok, data_data_ok},
            vecs[i].is_data ? 32'd1 : 32'd2);
        chk($sformatf("v%0d_rdata", i), vecs[i].is_data ? data_rdata : inst_rdata, vecs[i].rdata);
        tick();
        rvalid = 0; rdata = 0;
      end
      smp();
      chk($sformatf("v%0d_idle", i), {27'd0, arvalid, awvalid, wvalid, inst_data_ok, data_data_ok}, 32'd0);
      tick();
    end

    // Priority: data beats inst, inst stays pending and is served after data_data_ok.
    inst_req = 1; inst_addr = 32'hBFC00040;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80002000;
    smp();
    chk("pri_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    tick();
    data_req = 0; arready = 1;
    smp();
    chk("pri_arid_araddr", {arid, araddr[27:0]}, {4'd1, 28'h0002000});
    chk("pri_inst_wait1", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    arready = 0; rvalid = 1; rdata = 32'h11223344;
    smp();
    chk("pri_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    chk("pri_inst_wait2", {31'd0, inst_addr_ok}, 32'd0);
    tick();
    rvalid = 0;
    smp();
    chk("pri_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 0; arready = 1;
    smp();
    chk("pri_inst_ar", {arid, araddr[27:0]}, {4'd0, 28'hFC00040});
    tick();
    arready = 0; rvalid = 1; rdata = 32'h55667788;
    smp();
    chk("pri_inst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    chk("pri_inst_rdata", inst_rdata, 32'h55667788);
    tick();
    rvalid = 0;

    // AW accepted three cycles ahead of W: one response, one completion pulse.
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h80003000; data_wdata = 32'hA5A55A5A;
    tick();
    data_req = 0; awready = 1;
    smp();
    chk("split_both_valid", {30'd0, awvalid, wvalid}, 32'd3);
    tick();
    awready = 0;
    for (int c = 0; c < 2; c++) begin
      smp();
      chk($sformatf("split_w_held%0d", c), {30'd0, awvalid, wvalid}, 32'd1);
      tick();
    end
    wready = 1;
    smp();
    chk("split_w_only", {29'd0, awvalid, wvalid, bready}, 32'd2);
    tick();
    wready = 0;
    smp();
    chk("split_resp_wait", {28'd0, awvalid, wvalid, bready, data_data_ok}, 32'd2);
    tick();
    bvalid = 1;
    smp();
    chk("split_data_ok", {31'd0, data_data_ok}, 32'd1);
    tick();
    bvalid = 0;
    smp();
    chk("split_single_pulse", {30'd0, data_data_ok, bready}, 32'd0);
    tick();

    // Asynchronous reset while waiting on read data.
    inst_req = 1; inst_addr = 32'hBFC00080;
    tick();
    inst_req = 0; arready = 1;
    tick();
    arready = 0;
    smp();
    chk("rst_mid_rready_before", {31'd0, rready}, 32'd1);
    #2;
    areset = 1; rvalid = 1;
    #1;
    chk("rst_mid_quiet", {28'd0, arvalid, rready, inst_data_ok, data_data_ok}, 32'd0);
    tick();
    areset = 0; rvalid = 0;
    inst_req = 1; inst_addr = 32'hBFC000C0;
    smp();
    chk("rst_mid_reaccept", {31'd0, inst_addr_ok}, 32'd1);
    tick();
    inst_req = 0; arready = 1;
    smp();
    chk("rst_mid_araddr", araddr, 32'hBFC000C0);
    tick();
    arready = 0; rvalid = 1; rdata = 32'h0BADF00D;
    smp();
    chk("rst_mid_data_ok", {31'd0, inst_data_ok}, 32'd1);
    tick();
    rvalid = 0;

`ifdef AXI_BRIDGE_RESP_CHECK_EN
    // Error response on a load sets the sticky flag without disturbing completion.
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80004000;
    tick();
    data_req = 0; arready = 1;
    tick();
    arready = 0; rvalid = 1; rresp = 2'b10;
    smp();
    chk("err_before", {31'd0, bus_err}, 32'd0);
    chk("err_data_ok", {31'd0, data_data_ok}, 32'd1);
    tick();
    rvalid = 0; rresp = 2'b00;
    smp();
    chk("err_set", {31'd0, bus_err}, 32'd1);
    tick();
    data_req = 1;
    tick();
    data_req = 0; arready = 1;
    tick();
    arready = 0; rvalid = 1;
    tick();
    rvalid = 0;
    smp();
    chk("err_sticky", {31'd0, bus_err}, 32'd1);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
